// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: control bit positions, ALU opcode
// and funct encodings, and the multiplier FSM state encoding.
package ex_pkg;

    localparam int CTRL_ALU_SRC   = 0;
    localparam int CTRL_ALU_OP_LO = 1;
    localparam int CTRL_ALU_OP_HI = 2;
    localparam int CTRL_MUL_EN    = 3;

    typedef enum logic [1:0] {
        ALU_OP_ADD     = 2'b00,
        ALU_OP_SUB     = 2'b01,
        ALU_OP_FUNCT   = 2'b10,
        ALU_OP_ADD_ALT = 2'b11
    } alu_op_t;

    // {funct7[5], funct3}
    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b1000;
    localparam logic [3:0] FN_SLL  = 4'b0001;
    localparam logic [3:0] FN_SLT  = 4'b0010;
    localparam logic [3:0] FN_SLTU = 4'b0011;
    localparam logic [3:0] FN_XOR  = 4'b0100;
    localparam logic [3:0] FN_SRL  = 4'b0101;
    localparam logic [3:0] FN_SRA  = 4'b1101;
    localparam logic [3:0] FN_OR   = 4'b0110;
    localparam logic [3:0] FN_AND  = 4'b0111;

    localparam logic [2:0] F3_MUL   = 3'b000;
    localparam logic [2:0] F3_MULHU = 3'b011;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 unsigned shift-add multiplier producing a 64-bit product.
//   state    | meaning
//   IDLE     | waiting; a start latches operands and clears the accumulator
//   BUSY     | one shift-add step per cycle, 32 steps
//   DONE     | product valid for one cycle, then back to IDLE
module mul_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    mul_state_t  state, state_nxt;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [4:0]  count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MUL_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start) state_nxt = MUL_BUSY;
            MUL_BUSY: if (count == 5'd31) state_nxt = MUL_DONE;
            MUL_DONE: state_nxt = MUL_IDLE;
            default:  state_nxt = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (state == MUL_IDLE && start) begin
            mcand  <= {32'd0, op_a};
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
        end else if (state == MUL_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
        end
    end

    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative multiplier, feeding the
// registered EX/MEM boundary; stalls upstream while a multiply runs.
module ex_stage
    import ex_pkg::*;
#(
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc_incr_i,
    input  logic [31:0]           rd_rdata1_i,
    input  logic [31:0]           rd_rdata2_i,
    input  logic [4:0]            reg_wr_reg_i,
    input  logic [31:0]           imm_se_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_q2_i,
    input  logic [3:0]            funct_i,
    output logic                  stall_o,
    output logic [31:0]           alu_result_o,
    output logic                  zero_o,
    output logic [31:0]           rd_rdata2_o,
    output logic [4:0]            reg_wr_reg_o,
    output logic [31:0]           pc_incr_o,
    output logic [CTRL_WIDTH-5:0] ctrl_q3_o
);

    logic        alu_src;
    logic        mul_en;
    alu_op_t     alu_op;
    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    logic        mul_req, mul_ok, mul_start;
    logic        mul_busy, mul_done;
    logic [63:0] mul_product;
    logic        sel_hi;

    assign alu_src = ctrl_q2_i[CTRL_ALU_SRC];
    assign mul_en  = ctrl_q2_i[CTRL_MUL_EN];
    assign alu_op  = alu_op_t'(ctrl_q2_i[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]);

    assign op_a  = rd_rdata1_i;
    assign op_b  = alu_src ? imm_se_i : rd_rdata2_i;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = op_a + op_b;
        case (alu_op)
            ALU_OP_SUB: alu_res = op_a - op_b;
            ALU_OP_FUNCT: begin
                case (funct_i)
                    FN_SUB:  alu_res = alu_src ? (op_a + op_b) : (op_a - op_b);
                    FN_SLL:  alu_res = op_a << shamt;
                    FN_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
                    FN_SLTU: alu_res = {31'd0, op_a < op_b};
                    FN_XOR:  alu_res = op_a ^ op_b;
                    FN_SRL:  alu_res = op_a >> shamt;
                    FN_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
                    FN_OR:   alu_res = op_a | op_b;
                    FN_AND:  alu_res = op_a & op_b;
                    default: alu_res = op_a + op_b;
                endcase
            end
            default: alu_res = op_a + op_b;
        endcase
    end

    assign mul_req   = mul_en && (alu_op == ALU_OP_FUNCT);
    assign mul_ok    = (funct_i[2:0] == F3_MUL) || (funct_i[2:0] == F3_MULHU);
    assign mul_start = mul_req && mul_ok;

    mul_iter u_mul_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .op_a    (op_a),
        .op_b    (rd_rdata2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The held instruction is still presented during DONE; that cycle must not restart.
    assign stall_o = (mul_start && !mul_busy && !mul_done) || mul_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       sel_hi <= 1'b0;
        else if (mul_start && !mul_busy && !mul_done)     sel_hi <= (funct_i[2:0] == F3_MULHU);
    end

    always_comb begin
        ex_result = alu_res;
        if (mul_done)     ex_result = sel_hi ? mul_product[63:32] : mul_product[31:0];
        else if (mul_req) ex_result = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_o <= '0;
            zero_o       <= 1'b0;
            rd_rdata2_o  <= '0;
            reg_wr_reg_o <= '0;
            pc_incr_o    <= '0;
            ctrl_q3_o    <= '0;
        end else if (stall_o) begin
            alu_result_o <= '0;
            zero_o       <= 1'b0;
            rd_rdata2_o  <= '0;
            reg_wr_reg_o <= '0;
            pc_incr_o    <= '0;
            ctrl_q3_o    <= '0;
        end else begin
            alu_result_o <= ex_result;
            zero_o       <= (ex_result == 32'd0);
            rd_rdata2_o  <= rd_rdata2_i;
            reg_wr_reg_o <= reg_wr_reg_i;
            pc_incr_o    <= pc_incr_i;
            ctrl_q3_o    <= ctrl_q2_i[CTRL_WIDTH-1:4];
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, randomized ALU traffic against a
// behavioural model, and hand-written multiply/reset sequences.
module tb_ex_stage;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   pc_incr_i, rd_rdata1_i, rd_rdata2_i, imm_se_i;
    logic [4:0]    reg_wr_reg_i;
    logic [CW-1:0] ctrl_q2_i;
    logic [3:0]    funct_i;
    logic          stall_o, zero_o;
    logic [31:0]   alu_result_o, rd_rdata2_o, pc_incr_o;
    logic [4:0]    reg_wr_reg_o;
    logic [CW-5:0] ctrl_q3_o;

    int checks   = 0;
    int failures = 0;

    ex_stage #(.CTRL_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_incr_i    (pc_incr_i),
        .rd_rdata1_i  (rd_rdata1_i),
        .rd_rdata2_i  (rd_rdata2_i),
        .reg_wr_reg_i (reg_wr_reg_i),
        .imm_se_i     (imm_se_i),
        .ctrl_q2_i    (ctrl_q2_i),
        .funct_i      (funct_i),
        .stall_o      (stall_o),
        .alu_result_o (alu_result_o),
        .zero_o       (zero_o),
        .rd_rdata2_o  (rd_rdata2_o),
        .reg_wr_reg_o (reg_wr_reg_o),
        .pc_incr_o    (pc_incr_o),
        .ctrl_q3_o    (ctrl_q3_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  ctl;
        logic [3:0]  fn;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: instruction semantics stated directly as arithmetic.
    function automatic logic [31:0] ref_ex(input logic [31:0] a, input logic [31:0] rs2,
                                           input logic [31:0] imm, input logic [3:0] ctl,
                                           input logic [3:0] fn);
        logic [31:0]     b;
        longint unsigned prod;
        int              sh;
        b  = ctl[0] ? imm : rs2;
        sh = int'(b % 32);
        if (ctl[3] && ctl[2:1] == 2'b10) begin
            prod = longint'(a) * longint'(rs2);
            if (fn[2:0] == 3'b000) return prod[31:0];
            if (fn[2:0] == 3'b011) return prod[63:32];
            return 32'd0;
        end
        if (ctl[2:1] == 2'b01) return a - b;
        if (ctl[2:1] != 2'b10) return a + b;
        case (fn)
            4'b1000: return ctl[0] ? a + b : a - b;
            4'b0001: return a << sh;
            4'b0010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return 32'($signed(a) >>> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    task automatic drive(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [3:0] ctl, input logic [3:0] fn, input logic [11:0] up,
                         input logic [4:0] rd, input logic [31:0] pc);
        rd_rdata1_i  = rs1;
        rd_rdata2_i  = rs2;
        imm_se_i     = imm;
        ctrl_q2_i    = {up, ctl};
        funct_i      = fn;
        reg_wr_reg_i = rd;
        pc_incr_i    = pc;
    endtask

    task automatic apply_vec(input string nm, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [3:0] ctl, input logic [3:0] fn,
                             input logic [31:0] exp);
        logic [11:0] up;
        logic [4:0]  rd;
        logic [31:0] pc;
        up = 12'($urandom);
        rd = 5'($urandom);
        pc = $urandom;
        drive(rs1, rs2, imm, ctl, fn, up, rd, pc);
        #1;
        chk({nm, "_stall"}, 96'(stall_o), 96'(0));
        tick();
        chk({nm, "_result"}, 96'(alu_result_o), 96'(exp));
        chk({nm, "_zero"}, 96'(zero_o), 96'(exp == 32'd0));
        chk({nm, "_pass"}, {rd_rdata2_o, reg_wr_reg_o, pc_incr_o, ctrl_q3_o},
            {rs2, rd, pc, up});
    endtask

    task automatic do_mul(input string nm, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [2:0] f3);
        logic [11:0]     up;
        logic [4:0]      rd;
        logic [31:0]     pc;
        logic [31:0]     exp;
        longint unsigned prod;
        int              n;
        int              bub_bad;
        up   = 12'($urandom);
        rd   = 5'($urandom);
        pc   = $urandom;
        prod = longint'(rs1) * longint'(rs2);
        exp  = (f3 == 3'b011) ? prod[63:32] : prod[31:0];
        drive(rs1, rs2, $urandom, 4'b1100, {1'($urandom), f3}, up, rd, pc);
        #1;
        n       = 0;
        bub_bad = 0;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            tick();
            if ({ctrl_q3_o, reg_wr_reg_o, alu_result_o, rd_rdata2_o, pc_incr_o, zero_o} != '0)
                bub_bad++;
        end
        chk({nm, "_stall_cycles"}, 96'(n), 96'(33));
        chk({nm, "_bubbles"}, 96'(bub_bad), 96'(0));
        tick();
        chk({nm, "_result"}, 96'(alu_result_o), 96'(exp));
        chk({nm, "_pass"}, {rd_rdata2_o, reg_wr_reg_o, pc_incr_o, ctrl_q3_o},
            {rs2, rd, pc, up});
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {alu_result_o, zero_o, rd_rdata2_o, reg_wr_reg_o, pc_incr_o, ctrl_q3_o, stall_o},
            96'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 4'b0000, 4'b0000, 12'd0, 5'd0, 0);
        #12;
        chk_all_zero("reset_state");
        tick();
        rst_n = 1'b1;
        tick();

        // rs1, rs2, imm, ctl, fn, expected
        vecs.push_back('{32'd5,        32'd7,        32'd0,  4'b0100, 4'b1000, 32'hFFFFFFFE});
        vecs.push_back('{32'h80000000, 32'd0,        32'd4,  4'b0101, 4'b1101, 32'hF8000000});
        vecs.push_back('{32'd10,       32'd99,       32'd3,  4'b0101, 4'b1000, 32'd13});
        vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'd0,  4'b0100, 4'b0010, 32'd1});
        vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'd0,  4'b0100, 4'b0011, 32'd0});
        vecs.push_back('{32'd1,        32'd2,        32'd0,  4'b0000, 4'b0111, 32'd3});
        vecs.push_back('{32'd10,       32'd0,        32'd3,  4'b0011, 4'b0000, 32'd7});
        vecs.push_back('{32'd1,        32'hFFFFFFFF, 32'd0,  4'b0110, 4'b0100, 32'd0});
        vecs.push_back('{32'd1,        32'd31,       32'd0,  4'b0100, 4'b0001, 32'h80000000});
        vecs.push_back('{32'h80000000, 32'd31,       32'd0,  4'b0100, 4'b0101, 32'd1});
        vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 32'd0,  4'b0100, 4'b0100, 32'h0FF00FF0});
        vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 32'd0,  4'b0100, 4'b0110, 32'hFFF0FFF0});
        vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 32'd0,  4'b0100, 4'b0111, 32'hF000F000});
        vecs.push_back('{32'd6,        32'd4,        32'd0,  4'b0100, 4'b1010, 32'd10});
        vecs.push_back('{32'd6,        32'd4,        32'd0,  4'b1100, 4'b0001, 32'd0});

        foreach (vecs[i])
            apply_vec($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                      vecs[i].ctl, vecs[i].fn, vecs[i].exp);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b, im;
            logic [3:0]  c, f;
            a  = (i % 7 == 0) ? 32'h80000000 : $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            im = $urandom;
            c  = 4'($urandom);
            f  = 4'($urandom);
            if (c[3] && c[2:1] == 2'b10 && (f[2:0] == 3'b000 || f[2:0] == 3'b011)) c[3] = 1'b0;
            apply_vec($sformatf("rnd%0d", i), a, b, im, c, f, ref_ex(a, b, im, c, f));
        end

        do_mul("mul", 32'h00012345, 32'h00006789, 3'b000);
        do_mul("mulhu", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011);
        do_mul("mul_b2b", 32'hDEADBEEF, 32'h12345678, 3'b000);
        apply_vec("mul_unsup", 32'd9, 32'd9, 32'd0, 4'b1100, 4'b0001, 32'd0);
        for (int i = 0; i < 4; i++)
            do_mul($sformatf("mulrnd%0d", i), $urandom, $urandom, (i % 2 == 0) ? 3'b000 : 3'b011);

        drive(32'd3, 32'd5, 32'd0, 4'b1100, 4'b0000, 12'hABC, 5'd7, 32'h100);
        for (int i = 0; i < 11; i++) tick();
        drive(32'd3, 32'd5, 32'd0, 4'b0000, 4'b0000, 12'hABC, 5'd7, 32'h100);
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_mul");
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_reset_stall", 96'(stall_o), 96'(0));
        tick();
        chk("post_reset_add", 96'(alu_result_o), 96'(8));
        do_mul("mul_after_reset", 32'h00000007, 32'h00000009, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
